// File: rtl/dmem_stall_responder.sv
// dmem_stall_responder: variable-latency 16-bit data memory for the memory stage.
// One access is in flight at a time. The core is held with stall, and the access
// completes with a one-cycle done pulse. A malformed request (odd address, or
// rd and wr together) still runs the full latency, then raises err and does nothing.
module dmem_stall_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // WAIT lasts LATENCY-1 cycles: it counts down from LATENCY-2 to 0, inclusive.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                state;
  state_t                state_next;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic [15:0]           wdata;
  logic                  rd_cap;
  logic                  wr_cap;
  logic                  bad_cap;
  logic                  req;
  logic                  bad_req;
  logic [15:0]           mem [0:(2**DEPTH_LOG2)-1];

  // The address bits above the word index are ignored, so addresses wrap.
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^addr[15:DEPTH_LOG2+1];

  assign req     = rd | wr;
  assign bad_req = addr[0] | (rd & wr);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic. Request inputs are looked at only in IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req) state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the request when it is accepted, and run the latency counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= 4'd0;
      idx     <= '0;
      wdata   <= 16'd0;
      rd_cap  <= 1'b0;
      wr_cap  <= 1'b0;
      bad_cap <= 1'b0;
    end else if (state == IDLE && req) begin
      cnt     <= CNT_INIT;
      idx     <= addr[DEPTH_LOG2:1];
      wdata   <= data_in;
      rd_cap  <= rd;
      wr_cap  <= wr;
      bad_cap <= bad_req;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // The write commits on the edge that ends RESP.
  // It is dropped if the request was malformed or if reset is asserted on that edge.
  always_ff @(posedge clk) begin
    if (rst && state == RESP && wr_cap && !bad_cap) mem[idx] <= wdata;
  end

  // Output decode.
  // stall in IDLE is gated by reset, because no request is accepted while reset is held.
  always_comb begin
    stall    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    data_out = 16'd0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE: stall = rst & req;
      WAIT: stall = 1'b1;
      RESP: begin
        done = 1'b1;
        err  = bad_cap;
        if (rd_cap && !bad_cap) data_out = mem[idx];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_stall_responder.sv
// Directed plus randomized bench for dmem_stall_responder.
// Two instances are checked: the default build (LATENCY=3) and a LATENCY=1 build.
// Expected timing is counted in cycles from the moment a request is presented.
// Expected data comes from a word-array model that remembers every successful write.
module tb_dmem_stall_responder;

  localparam int LAT = 3;
  localparam int DL  = 10;
  localparam int NW  = 1 << DL;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, data_in, data_out;
  logic        rd, wr, stall, done, busy, err;
  logic [15:0] addr1, data_in1, data_out1;
  logic        rd1, wr1, stall1, done1, busy1, err1;

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_mem   [0:NW-1];
  bit          ref_known [0:NW-1];

  dmem_stall_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr),
    .data_out(data_out), .stall(stall), .done(done), .busy(busy), .err(err)
  );

  dmem_stall_responder #(.DEPTH_LOG2(DL), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .addr(addr1), .data_in(data_in1), .rd(rd1), .wr(wr1),
    .data_out(data_out1), .stall(stall1), .done(done1), .busy(busy1), .err(err1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input string what, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with no request: every output must stay low.
  task automatic idle(input int n, input string tag);
    rd = 1'b0;
    wr = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, "stall", {15'd0, stall}, 16'd0);
      check(tag, "done",  {15'd0, done},  16'd0);
      check(tag, "busy",  {15'd0, busy},  16'd0);
      check(tag, "err",   {15'd0, err},   16'd0);
      check(tag, "data",  data_out,       16'd0);
      tick();
    end
  endtask

  // One access. Inputs are held through the stall cycles (0..LAT-1), and done is
  // expected in cycle LAT. The model is updated once the write has committed.
  task automatic access(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d, input string tag);
    int ix;
    bit bad;
    ix  = int'(a >> 1) % NW;
    bad = a[0] | (r & w);
    for (int k = 0; k <= LAT; k++) begin
      if (k < LAT) begin
        rd = r; wr = w; addr = a; data_in = d;
      end else begin
        rd = 1'b0; wr = 1'b0; addr = 16'($urandom); data_in = 16'($urandom);
      end
      @(negedge clk);
      check(tag, "stall", {15'd0, stall}, 16'(k < LAT));
      check(tag, "done",  {15'd0, done},  16'(k == LAT));
      check(tag, "busy",  {15'd0, busy},  16'(k > 0));
      check(tag, "err",   {15'd0, err},   16'((k == LAT) && bad));
      if (k < LAT || bad) check(tag, "data", data_out, 16'd0);
      else if (r && ref_known[ix]) check(tag, "data", data_out, ref_mem[ix]);
      tick();
    end
    if (w && !bad) begin
      ref_mem[ix]   = d;
      ref_known[ix] = 1'b1;
    end
  endtask

  initial begin
    int per;
    logic [15:0] ra, rdat;
    int op;
    for (int i = 0; i < NW; i++) ref_known[i] = 1'b0;
    rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = 16'd0; data_in = 16'd0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 16'd0; data_in1 = 16'd0;

    // Reset state.
    tick();
    @(negedge clk);
    check("reset", "stall", {15'd0, stall}, 16'd0);
    check("reset", "done",  {15'd0, done},  16'd0);
    check("reset", "busy",  {15'd0, busy},  16'd0);
    check("reset", "err",   {15'd0, err},   16'd0);
    check("reset", "data",  data_out,       16'd0);
    tick();
    rst = 1'b1;
    idle(1, "post_reset");

    // Read after write.
    access(0, 1, 16'h0010, 16'hBEEF, "raw_wr");
    access(1, 0, 16'h0010, 16'h0000, "raw_rd");
    check("raw", "model", ref_mem[8], 16'hBEEF);

    // Unaligned write is flagged and suppressed.
    access(0, 1, 16'h0011, 16'h1234, "unaligned");
    access(1, 0, 16'h0010, 16'h0000, "unaligned_rd");

    // rd and wr together is flagged, and the word is left unchanged.
    access(0, 1, 16'h0020, 16'hC0DE, "both_pre");
    access(1, 1, 16'h0020, 16'hFFFF, "both");
    access(1, 0, 16'h0020, 16'h0000, "both_rd");

    // Address wrap.
    access(0, 1, 16'h0802, 16'h5A5A, "wrap_wr");
    access(1, 0, 16'h0002, 16'h0000, "wrap_rd");

    // A read held continuously: done comes every LAT+1 cycles, never back-to-back.
    per = LAT + 1;
    rd = 1'b1; wr = 1'b0; addr = 16'h0010;
    for (int c = 0; c < 3 * per; c++) begin
      @(negedge clk);
      check("held", "done",  {15'd0, done},  16'((c % per) == LAT));
      check("held", "busy",  {15'd0, busy},  16'((c % per) != 0));
      check("held", "stall", {15'd0, stall}, 16'((c % per) != LAT));
      check("held", "data",  data_out, ((c % per) == LAT) ? 16'hBEEF : 16'h0000);
      tick();
    end
    idle(2, "held_end");

    // Reset during WAIT drops the pending write.
    access(0, 1, 16'h0030, 16'h1111, "rstwait_pre");
    rd = 1'b0; wr = 1'b1; addr = 16'h0030; data_in = 16'h7777;
    @(negedge clk);
    check("rstwait", "stall", {15'd0, stall}, 16'd1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idle(4, "rstwait");
    access(1, 0, 16'h0030, 16'h0000, "rstwait_rd");

    // Reset asserted in the RESP cycle of a write also drops the write.
    access(0, 1, 16'h0040, 16'h2222, "rstresp_pre");
    rd = 1'b0; wr = 1'b1; addr = 16'h0040; data_in = 16'h9999;
    for (int k = 0; k < LAT; k++) tick();
    rd = 1'b0; wr = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1;
    idle(1, "rstresp");
    access(1, 0, 16'h0040, 16'h0000, "rstresp_rd");

    // Randomized accesses, with gaps, odd addresses and upper-bit aliasing.
    for (int n = 0; n < 40; n++) begin
      idle(int'($urandom_range(0, 2)), "rand_gap");
      op   = int'($urandom_range(1, 3));
      ra   = 16'($urandom_range(0, 15) << 1) | 16'($urandom_range(0, 3) << 11);
      if ($urandom_range(0, 7) == 0) ra[0] = 1'b1;
      rdat = 16'($urandom);
      access(op[0], op[1], ra, rdat, "rand");
    end

    // LATENCY=1 build: write, then read back.
    wr1 = 1'b1; addr1 = 16'h0004; data_in1 = 16'hABCD;
    @(negedge clk);
    check("lat1_wr", "stall", {15'd0, stall1}, 16'd1);
    check("lat1_wr", "done",  {15'd0, done1},  16'd0);
    tick();
    wr1 = 1'b0;
    @(negedge clk);
    check("lat1_wr", "done",  {15'd0, done1},  16'd1);
    check("lat1_wr", "stall", {15'd0, stall1}, 16'd0);
    tick();
    rd1 = 1'b1; addr1 = 16'h0004;
    @(negedge clk);
    check("lat1_rd", "stall", {15'd0, stall1}, 16'd1);
    check("lat1_rd", "busy",  {15'd0, busy1},  16'd0);
    tick();
    rd1 = 1'b0;
    @(negedge clk);
    check("lat1_rd", "done",  {15'd0, done1},  16'd1);
    check("lat1_rd", "busy",  {15'd0, busy1},  16'd1);
    check("lat1_rd", "data",  data_out1,       16'hABCD);
    check("lat1_rd", "err",   {15'd0, err1},   16'd0);
    tick();
    @(negedge clk);
    check("lat1_end", "done", {15'd0, done1},  16'd0);
    check("lat1_end", "busy", {15'd0, busy1},  16'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
